// File: rtl/m2p_lpm_request.sv
// Method-to-pipe marshaller for the LpmRequest link: packs enter/write calls into
// 144-bit pipe messages and queues them in a small FIFO drained over a PipeIn client.
module m2p_lpm_request #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  // LpmRequest server side
  input  logic           i_enter_ena,
  input  logic [31:0]    i_enter_data,
  output logic           o_enter_rdy,
  input  logic           i_write_ena,
  input  logic [31:0]    i_write_addr,
  input  logic [31:0]    i_write_data,
  output logic           o_write_rdy,
  // PipeIn client side
  output logic           o_enq_ena,
  output logic [143:0]   o_enq_v,
  input  logic           i_enq_rdy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);
  localparam logic [15:0] IdxEnter = 16'd0;
  localparam logic [15:0] IdxWrite = 16'd1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("m2p_lpm_request: DEPTH must be a power of two and at least 2");
  end

  function automatic logic [143:0] pack_msg(input logic [15:0] idx, input logic [31:0] a,
                                            input logic [31:0] d);
    return {idx, 16'h0000, a, d, 48'h0};
  endfunction

  logic [143:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [AW:0]   w_free;
  logic          w_do_write;
  logic          w_do_enter;
  logic          w_deq;
  logic [AW:0]   w_n_enq;
  logic [AW-1:0] w_enter_ptr;
  logic [143:0]  w_write_msg;
  logic [143:0]  w_enter_msg;

  // RDYs come from the registered count only, so enq_rdy never reaches them.
  always_comb begin
    w_free      = DepthC - r_count;
    o_write_rdy = (w_free >= (AW + 1)'(1));
    o_enter_rdy = (w_free >= (AW + 1)'(2));
    w_do_write  = i_write_ena && o_write_rdy;
    w_do_enter  = i_enter_ena && o_enter_rdy;
    w_n_enq     = (AW + 1)'(w_do_write) + (AW + 1)'(w_do_enter);
    w_enter_ptr = r_wptr + AW'(w_do_write);
    w_write_msg = pack_msg(IdxWrite, i_write_addr, i_write_data);
    w_enter_msg = pack_msg(IdxEnter, i_enter_data, 32'h0);
    o_enq_ena   = (r_count != '0);
    o_enq_v     = o_enq_ena ? r_mem[r_rptr] : '0;
    w_deq       = o_enq_ena && i_enq_rdy;
  end

  // Write lands first, enter after it; the two slots never collide.
  always_ff @(posedge i_clk) begin
    if (w_do_write) r_mem[r_wptr] <= w_write_msg;
    if (w_do_enter) r_mem[w_enter_ptr] <= w_enter_msg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + w_n_enq[AW-1:0];
      r_rptr  <= r_rptr + AW'(w_deq);
      r_count <= r_count + w_n_enq - (AW + 1)'(w_deq);
    end
  end

endmodule

// File: tb/tb_m2p_lpm_request.sv
// Randomized self-checking bench for m2p_lpm_request against a queue-based reference model.
module tb_m2p_lpm_request;

  localparam int unsigned DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         enter_ena;
  logic [31:0]  enter_data;
  logic         enter_rdy;
  logic         write_ena;
  logic [31:0]  write_addr;
  logic [31:0]  write_data;
  logic         write_rdy;
  logic         enq_ena;
  logic [143:0] enq_v;
  logic         enq_rdy;

  int unsigned  n_vec;
  int unsigned  n_err;
  logic [143:0] model_q[$];

  m2p_lpm_request #(.DEPTH(DEPTH)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enter_ena  (enter_ena),
    .i_enter_data (enter_data),
    .o_enter_rdy  (enter_rdy),
    .i_write_ena  (write_ena),
    .i_write_addr (write_addr),
    .i_write_data (write_data),
    .o_write_rdy  (write_rdy),
    .o_enq_ena    (enq_ena),
    .o_enq_v      (enq_v),
    .i_enq_rdy    (enq_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Method strobes must never be raised without their RDY.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(enter_ena && !enter_rdy)) else $error("protocol: enter without RDY");
      assert (!(write_ena && !write_rdy)) else $error("protocol: write without RDY");
    end
  end

  function automatic logic [143:0] msg_of(input int unsigned idx, input logic [31:0] a,
                                          input logic [31:0] d);
    logic [143:0] m;
    m = 144'(idx) << 128;
    m = m | (144'(a) << 80);
    m = m | (144'(d) << 48);
    return m;
  endfunction

  task automatic check_val(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int unsigned sz;
    sz = model_q.size();
    check_val("enq_ena", 144'(enq_ena), 144'(sz != 0));
    check_val("enq_v", enq_v, (sz != 0) ? model_q[0] : 144'h0);
    check_val("enter_rdy", 144'(enter_rdy), 144'((DEPTH - sz) >= 2));
    check_val("write_rdy", 144'(write_rdy), 144'((DEPTH - sz) >= 1));
  endtask

  // One clock: drive, check pre-edge outputs, clock, then advance the model.
  task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic ee, input logic [31:0] ed, input logic rdy);
    bit deq;
    write_ena  = we;
    write_addr = wa;
    write_data = wd;
    enter_ena  = ee;
    enter_data = ed;
    enq_rdy    = rdy;
    check_outputs();
    deq = (model_q.size() != 0) && rdy;
    @(posedge clk);
    if (deq) void'(model_q.pop_front());
    if (we) model_q.push_back(msg_of(1, wa, wd));
    if (ee) model_q.push_back(msg_of(0, ed, 32'h0));
    #1;
  endtask

  task automatic rand_step(input int unsigned rdy_pct);
    int unsigned free_slots;
    logic we, ee, rdy;
    free_slots = DEPTH - model_q.size();
    we  = (free_slots >= 1) && ($urandom_range(0, 1) == 1);
    ee  = (free_slots >= 2) && ($urandom_range(0, 1) == 1);
    rdy = ($urandom_range(0, 99) < rdy_pct);
    step(we, $urandom, $urandom, ee, $urandom, rdy);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    enter_ena  = 1'b0;
    enter_data = '0;
    write_ena  = 1'b0;
    write_addr = '0;
    write_data = '0;
    enq_rdy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single enter, then single write, each drained the following cycle.
    step(1'b0, 0, 0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check_val("enter_msg", enq_v, {16'h0, 16'h0, 32'hDEAD_BEEF, 80'h0});
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    check_val("enter_gone", 144'(enq_ena), 144'(0));
    step(1'b1, 32'h10, 32'h55AA, 1'b0, 0, 1'b1);
    check_val("write_msg", enq_v, {16'h1, 16'h0, 32'h10, 32'h55AA, 48'h0});
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);

    // Same-cycle write and enter: write emerges first.
    step(1'b1, 32'd1, 32'd2, 1'b1, 32'd3, 1'b1);
    check_val("same_cyc_w", enq_v, {16'h1, 16'h0, 32'd1, 32'd2, 48'h0});
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    check_val("same_cyc_e", enq_v, {16'h0, 16'h0, 32'd3, 80'h0});
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);

    // Fill under backpressure, then drain across the pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + i, 32'(i), 1'b0, 0, 1'b0);
    check_val("full_enter_rdy", 144'(enter_rdy), 144'(0));
    check_val("full_write_rdy", 144'(write_rdy), 144'(0));
    for (int i = 0; i < 4; i++) begin
      check_val("drain_addr", 144'(enq_v[111:80]), 144'(32'hA0 + i));
      step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    end

    // Concurrent enqueue/dequeue holding count at 3.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hB0 + i, 32'(i), 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, $urandom, 1'b0, 0, 1'b1);
      check_val("cnt3_model", 144'(model_q.size()), 144'(3));
      check_val("cnt3_enter_rdy", 144'(enter_rdy), 144'(0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 0, 1'b1);

    // Long randomized run.
    for (int i = 0; i < 300; i++) rand_step(60);
    for (int i = 0; i < 200; i++) rand_step(20);

    // Reset in mid-cycle with three messages queued.
    while (model_q.size() != 0) step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + i, 32'(i), 1'b0, 0, 1'b0);
    check_val("pre_rst_ena", 144'(enq_ena), 144'(1));
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_ena", 144'(enq_ena), 144'(0));
    check_val("rst_v", enq_v, 144'h0);
    check_val("rst_enter_rdy", 144'(enter_rdy), 144'(1));
    check_val("rst_write_rdy", 144'(write_rdy), 144'(1));
    model_q.delete();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 100; i++) rand_step(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
